// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and decode helpers for the fetch/decode/execute front end.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
      I_JXX, I_CALL:                    instr_len = 4'd9;
      default:                          instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic instr_ok(input logic [3:0] icode, input logic [3:0] ifun);
    case (icode)
      I_RRMOVQ, I_JXX: instr_ok = (ifun <= 4'd6);
      I_OPQ:           instr_ok = (ifun <= 4'd3);
      default:         instr_ok = (icode <= I_POPQ) && (ifun == 4'd0);
    endcase
  endfunction

  function automatic logic has_regids(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: has_regids = 1'b1;
      default: has_regids = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports, ID F reads as 0.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  input  logic [3:0]  dst_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] wr_e,
  input  logic [63:0] wr_m,
  output logic [63:0] val_a,
  output logic [63:0] val_b
);

  logic [63:0] regs [15];

  // NOTE: non-blocking assignments; the dstM write is placed last so it wins when dstE == dstM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= wr_e;
      if (dst_m != RNONE) regs[dst_m] <= wr_m;
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/y86_fde_core.sv
// Single-cycle Y86-64 fetch/decode/execute: byte-wide instruction memory, register file, ALU and CC.
module y86_fde_core
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] pc_i,
  input  logic        imem_we_i,
  input  logic [63:0] imem_waddr_i,
  input  logic [7:0]  imem_wdata_i,
  input  logic [63:0] wb_valE_i,
  input  logic [63:0] wb_valM_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_valid_o,
  output logic        imem_error_o,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o,
  output logic [63:0] valE_o,
  output logic        cnd_o
);

  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0] imem [IMEM_BYTES];

  // NOTE: program memory has no reset; its contents survive rst_n_i by design.
  always_ff @(posedge clk_i) begin
    if (imem_we_i && (imem_waddr_i < 64'(IMEM_BYTES))) imem[imem_waddr_i[AW-1:0]] <= imem_wdata_i;
  end

  // ---------------- Fetch ----------------
  logic [7:0]  ibytes [10];
  logic [3:0]  raw_icode, raw_ifun, raw_len, len;
  logic [64:0] last_addr;

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      ibytes[k] = ((pc_i + 64'(k)) < 64'(IMEM_BYTES)) ? imem[AW'(pc_i + 64'(k))] : 8'h00;
    end
  end

  assign raw_icode = ibytes[0][7:4];
  assign raw_ifun  = ibytes[0][3:0];
  assign raw_len   = instr_ok(raw_icode, raw_ifun) ? instr_len(raw_icode) : 4'd1;
  // 65-bit sum so a fetch wrapping past 2^64 is still flagged out of range.
  assign last_addr    = {1'b0, pc_i} + 65'(raw_len) - 65'd1;
  assign imem_error_o = (last_addr >= 65'(IMEM_BYTES));

  assign icode_o       = imem_error_o ? I_NOP : raw_icode;
  assign ifun_o        = imem_error_o ? 4'h0  : raw_ifun;
  assign instr_valid_o = instr_ok(icode_o, ifun_o);
  assign len           = instr_valid_o ? instr_len(icode_o) : 4'd1;
  assign valP_o        = pc_i + 64'(len);
  assign rA_o          = has_regids(icode_o) ? ibytes[1][7:4] : RNONE;
  assign rB_o          = has_regids(icode_o) ? ibytes[1][3:0] : RNONE;

  always_comb begin
    case (icode_o)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:
        valC_o = {ibytes[9], ibytes[8], ibytes[7], ibytes[6], ibytes[5], ibytes[4], ibytes[3], ibytes[2]};
      I_JXX, I_CALL:
        valC_o = {ibytes[8], ibytes[7], ibytes[6], ibytes[5], ibytes[4], ibytes[3], ibytes[2], ibytes[1]};
      default: valC_o = '0;
    endcase
  end

  // ---------------- Condition ----------------
  cc_t cc, cc_next;

  always_comb begin
    cnd_o = 1'b0;
    if (icode_o == I_RRMOVQ || icode_o == I_JXX) begin
      case (ifun_o)
        4'd0:    cnd_o = 1'b1;
        4'd1:    cnd_o = (cc.sf ^ cc.of) | cc.zf;
        4'd2:    cnd_o = cc.sf ^ cc.of;
        4'd3:    cnd_o = cc.zf;
        4'd4:    cnd_o = !cc.zf;
        4'd5:    cnd_o = !(cc.sf ^ cc.of);
        4'd6:    cnd_o = !(cc.sf ^ cc.of) && !cc.zf;
        default: cnd_o = 1'b0;
      endcase
    end
  end

  // ---------------- Decode ----------------
  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic       wr_ok;

  assign wr_ok = instr_valid_o && !imem_error_o;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode_o)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA_o;
      I_RET, I_POPQ:                     src_a = RSP;
      default: ;
    endcase
    case (icode_o)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:           src_b = rB_o;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:      src_b = RSP;
      default: ;
    endcase
    if (wr_ok) begin
      case (icode_o)
        I_RRMOVQ:                        dst_e = cnd_o ? rB_o : RNONE;
        I_IRMOVQ, I_OPQ:                 dst_e = rB_o;
        I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = RSP;
        default: ;
      endcase
      if (icode_o == I_MRMOVQ || icode_o == I_POPQ) dst_m = rA_o;
    end
  end

  y86_regfile u_regfile (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .src_a  (src_a),
    .src_b  (src_b),
    .dst_e  (dst_e),
    .dst_m  (dst_m),
    .wr_e   (wb_valE_i),
    .wr_m   (wb_valM_i),
    .val_a  (valA_o),
    .val_b  (valB_o)
  );

  // ---------------- Execute ----------------
  logic [63:0] alu_a, alu_b;
  alu_fun_e    alu_fun;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode_o)
      I_RRMOVQ, I_OPQ:              alu_a = valA_o;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC_o;
      I_CALL, I_PUSHQ:              alu_a = -64'sd8;
      I_RET, I_POPQ:                alu_a = 64'd8;
      default: ;
    endcase
    case (icode_o)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB_o;
      default: ;
    endcase
  end

  assign alu_fun = (icode_o == I_OPQ) ? alu_fun_e'(ifun_o[1:0]) : ALU_ADD;

  always_comb begin
    case (alu_fun)
      ALU_SUB: valE_o = alu_b - alu_a;
      ALU_AND: valE_o = alu_b & alu_a;
      ALU_XOR: valE_o = alu_b ^ alu_a;
      default: valE_o = alu_b + alu_a;
    endcase
  end

  always_comb begin
    cc_next.zf = (valE_o == '0);
    cc_next.sf = valE_o[63];
    case (alu_fun)
      ALU_ADD: cc_next.of = (alu_a[63] == alu_b[63]) && (valE_o[63] != alu_b[63]);
      ALU_SUB: cc_next.of = (alu_a[63] != alu_b[63]) && (valE_o[63] != alu_b[63]);
      default: cc_next.of = 1'b0;
    endcase
  end

  // An imem_error forces icode to nop, so only a genuine valid OPq reaches this enable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                cc <= CC_RESET;
    else if (icode_o == I_OPQ && instr_valid_o) cc <= cc_next;
  end

endmodule

// File: tb/tb_y86_fde_core.sv
// Directed bench for y86_fde_core: small hand-assembled program with hand-computed expectations.
module tb_y86_fde_core;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [63:0] pc_i = '0;
  logic        imem_we_i = 1'b0;
  logic [63:0] imem_waddr_i = '0;
  logic [7:0]  imem_wdata_i = '0;
  logic [63:0] wb_valE_i = '0;
  logic [63:0] wb_valM_i = '0;
  logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
  logic [63:0] valC_o, valP_o, valA_o, valB_o, valE_o;
  logic        instr_valid_o, imem_error_o, cnd_o;

  int n_checks = 0;
  int n_fail   = 0;

  y86_fde_core #(.IMEM_BYTES(1024)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .pc_i         (pc_i),
    .imem_we_i    (imem_we_i),
    .imem_waddr_i (imem_waddr_i),
    .imem_wdata_i (imem_wdata_i),
    .wb_valE_i    (wb_valE_i),
    .wb_valM_i    (wb_valM_i),
    .icode_o      (icode_o),
    .ifun_o       (ifun_o),
    .rA_o         (rA_o),
    .rB_o         (rB_o),
    .valC_o       (valC_o),
    .valP_o       (valP_o),
    .instr_valid_o(instr_valid_o),
    .imem_error_o (imem_error_o),
    .valA_o       (valA_o),
    .valB_o       (valB_o),
    .valE_o       (valE_o),
    .cnd_o        (cnd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writes n bytes taken from the top of b (first byte = b[79:72]) starting at base.
  task automatic load(input logic [63:0] base, input logic [79:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      imem_we_i    = 1'b1;
      imem_waddr_i = base + 64'(k);
      imem_wdata_i = b[79-8*k -: 8];
    end
    @(negedge clk_i);
    imem_we_i = 1'b0;
  endtask

  task automatic at(input logic [63:0] p);
    pc_i = p;
    #1;
  endtask

  task automatic tick(input logic [63:0] e, input logic [63:0] m);
    wb_valE_i = e;
    wb_valM_i = m;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    // Program load while held in reset, so no register or CC writes occur.
    load(0,    80'h30F2_0A00_0000_0000_0000, 10);
    load(10,   80'h30F3_0300_0000_0000_0000, 10);
    load(20,   80'h6023_6133_0000_0000_0000, 4);
    load(24,   80'h7340_0000_0000_0000_0000, 9);
    load(33,   80'h7440_0000_0000_0000_0000, 9);
    load(42,   80'hA02F_B00F_2001_B04F_A04F, 10);
    load(52,   80'hC067_2320_3100_0000_0000, 5);
    load(57,   80'h7340_0000_0000_0000_0000, 9);
    load(66,   80'h2421_2010_0000_0000_0000, 4);
    load(1019, 80'h30F2_0000_0000_0000_0000, 2);
    load(1023, 80'h0000_0000_0000_0000_0000, 1);

    at(0);
    check("rst_fetch_icode", 64'(icode_o), 64'h3);
    at(42);
    check("rst_valA", valA_o, 64'h0);
    at(33);
    check("rst_jne_cnd", 64'(cnd_o), 64'h0);

    @(negedge clk_i);
    rst_n_i = 1'b1;

    at(0);
    check("irmovq_icode", 64'(icode_o), 64'h3);
    check("irmovq_rA", 64'(rA_o), 64'hF);
    check("irmovq_rB", 64'(rB_o), 64'h2);
    check("irmovq_valC", valC_o, 64'd10);
    check("irmovq_valE", valE_o, 64'd10);
    check("irmovq_valP", valP_o, 64'd10);
    check("irmovq_valid", 64'(instr_valid_o), 64'h1);
    tick(64'd10, 64'd0);
    at(10);
    check("irmovq2_valE", valE_o, 64'd3);
    tick(64'd3, 64'd0);

    at(20);
    check("addq_valA", valA_o, 64'd10);
    check("addq_valB", valB_o, 64'd3);
    check("addq_valE", valE_o, 64'd13);
    check("addq_valP", valP_o, 64'd22);
    tick(64'd13, 64'd0);
    at(33);
    check("jne_after_add_cnd", 64'(cnd_o), 64'h1);

    at(22);
    check("subq_valA", valA_o, 64'd13);
    check("subq_valE", valE_o, 64'd0);
    tick(64'd0, 64'd0);
    at(24);
    check("je_cnd", 64'(cnd_o), 64'h1);
    check("je_valC", valC_o, 64'd64);
    check("je_valP", valP_o, 64'd33);
    at(33);
    check("jne_cnd", 64'(cnd_o), 64'h0);

    at(42);
    check("pushq_valA", valA_o, 64'd10);
    check("pushq_valE", valE_o, 64'hFFFF_FFFF_FFFF_FFF8);
    tick(64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
    at(44);
    check("popq_valA", valA_o, 64'hFFFF_FFFF_FFFF_FFF8);
    check("popq_valE", valE_o, 64'd0);
    tick(64'd0, 64'h55);
    at(46);
    check("rrmovq_R0", valA_o, 64'h55);
    check("rrmovq_valE", valE_o, 64'h55);
    tick(64'h55, 64'd0);
    at(48);
    check("popq_rsp_valE", valE_o, 64'd8);
    tick(64'd8, 64'h77);
    at(50);
    check("dstm_wins_valA", valA_o, 64'h77);
    check("pushq_rsp_valE", valE_o, 64'h6F);

    at(52);
    check("bad_icode_valid", 64'(instr_valid_o), 64'h0);
    check("bad_icode_valP", valP_o, 64'd53);
    tick(64'hDEAD, 64'hDEAD);
    at(53);
    check("bad_ifun_valid", 64'(instr_valid_o), 64'h0);
    check("bad_ifun_valP", valP_o, 64'd54);
    tick(64'hBEEF, 64'hBEEF);
    at(55);
    check("bad_no_reg_write", valA_o, 64'd0);
    at(57);
    check("bad_no_cc_write", 64'(cnd_o), 64'h1);

    at(66);
    check("cmovne_cnd", 64'(cnd_o), 64'h0);
    tick(64'd10, 64'd0);
    at(68);
    check("cmov_no_write", valA_o, 64'h55);

    at(1019);
    check("imem_err", 64'(imem_error_o), 64'h1);
    check("imem_err_icode", 64'(icode_o), 64'h1);
    check("imem_err_valP", valP_o, 64'd1020);
    tick(64'h99, 64'h99);
    at(42);
    check("imem_err_no_write", valA_o, 64'd10);
    check("imem_err_rsp", valB_o, 64'h77);
    at(1023);
    check("last_byte_err", 64'(imem_error_o), 64'h0);
    check("last_byte_valP", valP_o, 64'd1024);

    at(20);
    tick(64'd10, 64'd0);
    at(33);
    check("pre_rst_jne", 64'(cnd_o), 64'h1);

    at(42);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_valA", valA_o, 64'd0);
    check("async_rst_valB", valB_o, 64'd0);
    check("async_rst_valE", valE_o, 64'hFFFF_FFFF_FFFF_FFF8);
    pc_i = 64'd33;
    #1;
    check("async_rst_zf", 64'(cnd_o), 64'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_fde_core.md
Name: y86_fde_core

Overview:
- Fetch, decode and execute front end of the single-cycle Y86-64 processor.
- Fetch: reads the instruction at pc_i from an internal byte-wide instruction memory and splits it into fields.
- Decode: reads operands from a 15-entry register file; the file is written back from the memory/writeback stage.
- Execute: computes valE and cnd and holds the condition codes. Downstream blocks memory_access, writeback and pc_update consume the outputs.

Parameters:
- IMEM_BYTES, 1024: instruction memory size in bytes.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- pc_i  in  64  address of the current instruction.
- imem_we_i  in  1  instruction memory byte write enable (program load).
- imem_waddr_i  in  64  instruction memory byte write address.
- imem_wdata_i  in  8  instruction memory byte write data.
- wb_valE_i  in  64  writeback value for dstE.
- wb_valM_i  in  64  writeback value for dstM.
- icode_o  out  4  instruction code.
- ifun_o  out  4  function code.
- rA_o  out  4  register ID A.
- rB_o  out  4  register ID B.
- valC_o  out  64  constant word.
- valP_o  out  64  address of the next sequential instruction.
- instr_valid_o  out  1  instruction is legal.
- imem_error_o  out  1  fetch address out of range.
- valA_o  out  64  register read port A.
- valB_o  out  64  register read port B.
- valE_o  out  64  ALU result.
- cnd_o  out  1  branch/move condition.

Behaviour:
- Fetch (combinational)
  - Byte0 = {icode, ifun}.
  - Instruction lengths:
    - 1 byte: halt 0, nop 1, ret 9.
    - 2 bytes: rrmovq/cmovXX 2, OPq 6, pushq A, popq B.
    - 10 bytes: irmovq 3, rmmovq 4, mrmovq 5.
    - 9 bytes: jXX 7, call 8.
  - Register byte: rA = byte1[7:4], rB = byte1[3:0]; without a register byte, rA = rB = F.
  - valC: little-endian 8 bytes from byte2 for icodes 3/4/5, from byte1 for icodes 7/8; 0 otherwise.
  - valP = pc_i + length.
  - instr_valid_o = 0 for:
    - icode > B;
    - ifun > 6 for icode 2 or 7;
    - ifun > 3 for icode 6;
    - ifun != 0 for any other icode.
  - Invalid instructions use length 1.
  - imem_error_o = 1 when pc_i + length - 1 >= IMEM_BYTES. When set, icode is forced to 1 (nop), so every field decodes as nop.
  - The imem_we_i byte write is synchronous; memory contents are not cleared by reset.
- Decode
  - srcA = rA for icodes 2/4/6/A; 4 (RSP) for icodes 9/B; F otherwise.
  - srcB = rB for icodes 4/5/6; RSP for icodes 8/9/A/B; F otherwise.
  - Reading ID F returns 0.
  - Destination selection:
    - dstE = rB for icode 2 (only when cnd_o = 1), icode 3 and icode 6.
    - dstE = RSP for icodes 8/9/A/B.
    - dstM = rA for icodes 5/B.
  - Register writes happen on the rising edge with wb_valE_i / wb_valM_i.
  - No write when instr_valid_o = 0 or imem_error_o = 1.
  - When dstE == dstM, dstM wins.
  - Reads are combinational from current state; no write-through bypass.
  - Reset clears all 15 registers to 0.
- Execute
  - aluA = valA for icodes 2/6; valC for icodes 3/4/5; -8 for icodes 8/A; +8 for icodes 9/B.
  - aluB = valB for icodes 4/5/6/8/9/A/B; 0 for icodes 2/3.
  - Function is ifun for OPq (0 add, 1 sub = aluB - aluA, 2 and, 3 xor), add otherwise.
  - All 64-bit, wraps modulo 2^64.
  - CC {ZF, SF, OF} latches on the rising edge only for valid OPq.
  - OF: signed overflow for add/sub; 0 for and/xor.
  - CC reset value: ZF=1, SF=0, OF=0.
  - cnd_o is combinational, for icodes 2/7 only (0 for all other icodes). By ifun:
    - 0: 1
    - 1: (SF^OF)|ZF
    - 2: SF^OF
    - 3: ZF
    - 4: !ZF
    - 5: !(SF^OF)
    - 6: !(SF^OF) & !ZF
- All outputs are combinational functions of pc_i and state; latency is zero.
- Values during reset: register-derived values are 0, CC is at its reset value, and fetch outputs still follow memory.

Decomposition:
- Package y86_pkg holds:
  - icode constants;
  - ALU ifun codes;
  - condition codes;
  - RSP = 4, RNONE = F;
  - instruction-length helper function.
- One sub-module, y86_regfile: 15x64, two async read ports, two sync write ports, async reset.

Test Plan:
- Load `30 F2 0A00000000000000` at 0, pc_i=0 -> icode=3, rB=2, valC=10, valE=10, valP=10, instr_valid=1. Drive wb_valE_i=valE and clock -> R2=10.
- irmovq $3,%rbx at 10, then `60 23` at 20 -> valA=10, valB=3, valE=13, valP=22. After clock: R3=13, ZF=0.
- `61 33` at 22 -> valE=0, CC ZF=1. Then `73 + 4000000000000000` at 24 -> cnd=1, valC=64, valP=33. Then `74` -> cnd=0.
- `A0 2F` -> srcB=RSP, valE=RSP-8. `B0 0F` with wb_valM_i=0x55, wb_valE_i=RSP+8 -> R0=0x55.
- Byte 0xC0 -> instr_valid=0, valP=pc+1, no writes. irmovq at IMEM_BYTES-5 -> imem_error=1, no writes.
- Assert rst_n_i mid-run between edges -> registers immediately 0, ZF=1, valA/valB=0.
